if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage for the pipelined MIPS core. It owns the PC, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register for the decode stage. Stall and flush inputs come from hazard detection and branch resolution in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble word placed in IF/ID (sll $0,$0,0)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  run enable; fetch advances only while high
stall_i  in  1  hazard stall: hold PC and IF/ID (PCWrite/IF_IDWrite deasserted)
flush_i  in  1  branch/jump taken in ID: redirect PC, squash IF/ID
target_i  in  32  redirect address, valid when flush_i=1
imem_addr_o  out  32  instruction-memory address (= current PC)
imem_instr_i  in  32  instruction word at imem_addr_o
imem_ready_i  in  1  instruction word valid this cycle; 0 = wait state
pc_o  out  32  current PC
if_id_pc4_o  out  32  registered PC+4 of the instruction in IF/ID
if_id_instr_o  out  32  registered instruction
if_id_valid_o  out  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Reset (rst_i=1 at an edge, overrides everything): pc=RESET_PC, state=IDLE, if_id_pc4_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0. A reset mid-stall or mid-wait discards all pending state.
- imem_addr_o and pc_o are combinational copies of the pc register. Fetch latency: instruction at PC appears on if_id_* one edge after it is sampled.
- FSM states: IDLE, FETCH.
  - IDLE: pc held, IF/ID loaded with bubble each edge. Go to FETCH on the first edge with start_i=1. No instruction is captured on that edge.
  - FETCH: go to IDLE on an edge with start_i=0. pc is held and a bubble is inserted. A pending flush_i is still honoured on that edge.
- FETCH edge priority, highest first:
  1. flush_i=1: pc <= {target_i[31:2],2'b00}; IF/ID <= bubble (pc4=0, instr=NOP, valid=0). Flush beats stall and beats imem_ready_i=0.
  2. stall_i=1: pc and all IF/ID outputs hold their values unchanged.
  3. imem_ready_i=0: pc holds; IF/ID <= bubble.
  4. otherwise: pc <= pc+4; if_id_pc4_o <= pc+4; if_id_instr_o <= imem_instr_i; if_id_valid_o <= 1.
- The flush_i and stall_i rules also apply in IDLE. pc updates and IF/ID stays a bubble.
- Arithmetic: 32-bit unsigned, PC+4 wraps (32'hFFFF_FFFC -> 32'h0000_0000), no overflow flag. pc[1:0] is always 2'b00.
- Stalls are unbounded. Consecutive flushes each take effect; the last one wins.

Decomposition:
- Shared package cpu_pkg holds NOP_INSTR, the IDLE/FETCH state encoding (1 bit), and the IF/ID field widths for reuse by later pipeline registers.
- One natural sub-module is if_id_reg, a generic pipeline register with write-enable (hold) and flush (load bubble) inputs. It is reused for ID/EX later.
- The PC adder reuses the existing Adder block.

Test Plan:
- Reset then start: rst_i=1 for 2 cycles, start_i=1. pc_o goes 0 -> 4 -> 8. if_id_instr_o shows the words at 0 then 4, with valid=1 and if_id_pc4_o=4 then 8.
- Stall: at pc=8, stall_i=1 for 3 cycles. pc_o stays 8 and if_id_* stays frozen (pc4=8). After release, the next capture is the word at 8 with pc4=12.
- Flush over stall: stall_i=1 and flush_i=1 with target_i=32'h0000_0043. The next edge gives pc_o=32'h40, if_id_valid_o=0, if_id_instr_o=0.
- Wait state: imem_ready_i=0 for 2 cycles at pc=16. pc_o holds 16 with valid=0 both cycles. On ready, the word at 16 is captured with pc4=20.
- Wrap and start drop: pc=32'hFFFF_FFFC, then one normal edge gives pc_o=0 and if_id_pc4_o=0. Next, start_i=0 gives IDLE, pc held at 0 and a bubble.
- Reset mid-operation: assert rst_i while stall_i=1 at pc=32'h20. Next edge gives pc_o=RESET_PC and valid=0. Fetch does not resume until start_i is seen high in IDLE.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: bubble word, fetch FSM encoding and IF/ID layout.
// Later pipeline registers reuse these field widths.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_W      = 32;
  localparam int          INSTR_W   = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // Stand-in for the shared Adder block; 32-bit unsigned, wraps silently.
  function automatic logic [PC_W-1:0] adder(input logic [PC_W-1:0] a,
                                            input logic [PC_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: address out, word and ready back.
interface if_stage_if;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        imem_ready_i;

   modport master (output imem_addr_o, input imem_instr_i, input imem_ready_i);
   modport slave  (input imem_addr_o, output imem_instr_i, output imem_ready_i);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// Generic pipeline register: flush loads the bubble, otherwise loads d when we=1, else holds.
module if_id_reg #(
   parameter int               WIDTH  = 1,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush) q <= BUBBLE;
      else if (we)        q <= d;
   end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Flush redirects from any state; capture only happens while running in FETCH.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [31:0]       target_i,
   if_stage_if.master        imem,
   output logic [31:0]       pc_o,
   output logic [31:0]       if_id_pc4_o,
   output logic [31:0]       if_id_instr_o,
   output logic              if_id_valid_o
);

   localparam cpu_pkg::if_id_t BUBBLE = '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};

   cpu_pkg::fetch_state_e state, state_next;
   logic [31:0]           pc, pc_next, pc_plus4;
   logic                  ifid_we, ifid_flush;
   cpu_pkg::if_id_t       ifid_d, ifid_q;

   assign pc_plus4 = cpu_pkg::adder(pc, 32'd4);
   assign ifid_d   = '{pc4: pc_plus4, instr: imem.imem_instr_i, valid: 1'b1};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= cpu_pkg::IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_next = start_i ? cpu_pkg::FETCH : cpu_pkg::IDLE;
      pc_next    = pc;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      if (flush_i) begin
         pc_next    = {target_i[31:2], 2'b00};
         ifid_flush = 1'b1;
      end else if (state == cpu_pkg::FETCH && start_i) begin
         if (!stall_i) begin
            if (!imem.imem_ready_i) begin
               ifid_flush = 1'b1;
            end else begin
               pc_next = pc_plus4;
               ifid_we = 1'b1;
            end
         end
      end else begin
         // IDLE, the IDLE->FETCH edge and the start-drop edge all insert a bubble.
         ifid_flush = 1'b1;
      end
   end

   if_id_reg #(
      .WIDTH  (cpu_pkg::IF_ID_W),
      .BUBBLE (BUBBLE)
   ) u_if_id (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (ifid_we),
      .flush (ifid_flush),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign imem.imem_addr_o = pc;
   assign pc_o             = pc;
   assign if_id_pc4_o      = ifid_q.pc4;
   assign if_id_instr_o    = ifid_q.instr;
   assign if_id_valid_o    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan scenarios, then random traffic
// compared every cycle against a behavioural fetch model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst, start, stall, flush, ready;
   logic [31:0] target;
   logic [31:0] pc, pc4, instr;
   logic        valid;

   int checks = 0;
   int errors = 0;

   if_stage_if imem_bus ();

   if_stage u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .stall_i       (stall),
      .flush_i       (flush),
      .target_i      (target),
      .imem          (imem_bus.master),
      .pc_o          (pc),
      .if_id_pc4_o   (pc4),
      .if_id_instr_o (instr),
      .if_id_valid_o (valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_bus.imem_instr_i = mem_word(imem_bus.imem_addr_o);
   assign imem_bus.imem_ready_i = ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what IF/ID and PC must hold after each edge.
   logic [31:0] m_pc, m_pc4, m_instr;
   logic        m_valid, m_run;
   bit          m_live = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 0; m_run = 0; m_live = 1;
      end else if (m_live) begin
         if (flush) begin
            m_pc = target & ~32'h3;
            m_pc4 = 0; m_instr = 0; m_valid = 0;
         end else if (m_run && start) begin
            if (stall) begin
               // everything frozen
            end else if (!ready) begin
               m_pc4 = 0; m_instr = 0; m_valid = 0;
            end else begin
               m_instr = mem_word(m_pc);
               m_pc    = m_pc + 32'd4;
               m_pc4   = m_pc;
               m_valid = 1;
            end
         end else begin
            m_pc4 = 0; m_instr = 0; m_valid = 0;
         end
         m_run = start;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("model_pc",    pc,                   m_pc);
         check("model_addr",  imem_bus.imem_addr_o, m_pc);
         check("model_pc4",   pc4,                  m_pc4);
         check("model_instr", instr,                m_instr);
         check("model_valid", {31'b0, valid},       {31'b0, m_valid});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ifid(input string name, input logic [31:0] e_pc,
                              input logic [31:0] e_pc4, input logic [31:0] e_instr,
                              input logic e_valid);
      check({name, "_pc"},    pc,             e_pc);
      check({name, "_pc4"},   pc4,            e_pc4);
      check({name, "_instr"}, instr,          e_instr);
      check({name, "_valid"}, {31'b0, valid}, {31'b0, e_valid});
   endtask

   initial begin
      rst = 1; start = 1; stall = 0; flush = 0; ready = 1; target = 0;
      tick(); tick();
      expect_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 0;
      tick();                                      // IDLE -> FETCH, nothing captured
      expect_ifid("start_edge", 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      expect_ifid("fetch0", 32'h4, 32'h4, mem_word(32'h0), 1'b1);
      tick();
      expect_ifid("fetch4", 32'h8, 32'h8, mem_word(32'h4), 1'b1);

      stall = 1;
      repeat (3) begin
         tick();
         expect_ifid("stall", 32'h8, 32'h8, mem_word(32'h4), 1'b1);
      end
      stall = 0;
      tick();
      expect_ifid("release", 32'hC, 32'hC, mem_word(32'h8), 1'b1);

      stall = 1; flush = 1; target = 32'h0000_0043;
      tick();
      expect_ifid("flush_over_stall", 32'h40, 32'h0, 32'h0, 1'b0);
      stall = 0; target = 32'h0000_0010;
      tick();                                      // back-to-back flush, last wins
      expect_ifid("flush_to_16", 32'h10, 32'h0, 32'h0, 1'b0);

      flush = 0; ready = 0;
      repeat (2) begin
         tick();
         expect_ifid("wait_state", 32'h10, 32'h0, 32'h0, 1'b0);
      end
      ready = 1;
      tick();
      expect_ifid("ready_again", 32'h14, 32'h14, mem_word(32'h10), 1'b1);

      flush = 1; target = 32'hFFFF_FFFE;
      tick();
      check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
      flush = 0;
      tick();
      expect_ifid("wrap", 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1);
      start = 0;
      tick();
      expect_ifid("start_drop", 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      expect_ifid("idle_hold", 32'h0, 32'h0, 32'h0, 1'b0);

      start = 1;
      tick();
      flush = 1; target = 32'h20;
      tick();
      flush = 0; stall = 1; rst = 1;
      tick();
      expect_ifid("reset_mid_stall", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 0; stall = 0; start = 0;
      tick(); tick();
      check("idle_no_fetch", pc, 32'h0);
      start = 1;
      tick();
      check("resume_edge", pc, 32'h0);
      tick();
      expect_ifid("resume", 32'h4, 32'h4, mem_word(32'h0), 1'b1);

      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 199) == 0);
         start  = ($urandom_range(0, 15) != 0);
         stall  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 9) == 0);
         ready  = ($urandom_range(0, 3) != 0);
         target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                               : $urandom;
         tick();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
